// File: rtl/slave_mem_pkg.sv
// Shared constants and FIFO entry layout for the write master / slave_mem pair.
// The master uses ADDR_W and MAX_ADDR for its wrap point, so both sides agree on memory depth.
package slave_mem_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
   localparam logic [ADDR_W-1:0] MAX_ADDR = 8'h30;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/slave_mem_if.sv
// Valid/ready write channel between the write master and slave_mem.
// The returned-data path rides alongside the handshake.
interface slave_mem_if #(
   parameter int unsigned WIDTH  = slave_mem_pkg::DATA_W,
   parameter int unsigned ADDR_W = slave_mem_pkg::ADDR_W
);

   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  s_data_in;
   logic              ready;
   logic [WIDTH-1:0]  s_data_out;

   modport master (
      output valid,
      output addr,
      output s_data_in,
      input  ready,
      input  s_data_out
   );

   modport slave (
      input  valid,
      input  addr,
      input  s_data_in,
      output ready,
      output s_data_out
   );

endinterface

// File: rtl/slave_mem_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Push when full and pop when empty are ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = store[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      level <= level + LVL_W'(1);
         else if (do_pop && !do_push) level <= level - LVL_W'(1);
      end
   end

   // Storage needs no reset: stale entries are unreachable once level is zero.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= din;
   end

endmodule

// File: rtl/slave_mem.sv
// Write-channel receiver: buffers beats in a FIFO and drains them into a
// small register-file memory at a throttled rate, with a registered read port.
module slave_mem #(
   parameter int unsigned        WIDTH      = slave_mem_pkg::DATA_W,
   parameter int unsigned        ADDR_W     = slave_mem_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0]  MAX_ADDR   = ADDR_W'(slave_mem_pkg::MAX_ADDR),
   parameter int unsigned        FIFO_DEPTH = 4,
   parameter int unsigned        DRAIN_DIV  = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   slave_mem_if.slave                    bus,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic [WIDTH-1:0]              rd_data,
   output logic [15:0]                   wr_cnt,
   output logic                          err,
   input  logic                          err_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   import slave_mem_pkg::*;

   localparam int unsigned MEM_DEPTH = 32'(MAX_ADDR) + 1;
   localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
   localparam int unsigned DIV_W     = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
   localparam int unsigned ENT_W     = $bits(entry_t);

   logic [WIDTH-1:0] mem [MEM_DEPTH];
   logic [DIV_W-1:0] div_cnt;
   logic [WIDTH-1:0] resp;
   logic             drain_tick;
   logic             accept;
   logic             pop;
   logic             full;
   logic             empty;
   logic             head_ok;
   entry_t           push_ent;
   entry_t           head_ent;

   // Ready is the only combinational output; it must be low throughout reset.
   assign bus.ready      = !full && !rst;
   assign bus.s_data_out = resp;

   assign accept        = bus.valid && bus.ready;
   assign drain_tick    = (div_cnt == DIV_W'(DRAIN_DIV - 1));
   assign pop           = drain_tick && !empty;
   assign head_ok       = (head_ent.addr <= MAX_ADDR);
   assign push_ent.addr = bus.addr;
   assign push_ent.data = bus.s_data_in;

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .din   (push_ent),
      .dout  (head_ent),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   // Free-running drain throttle; with DRAIN_DIV=1 the tick is permanently high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             div_cnt <= '0;
      else if (drain_tick) div_cnt <= '0;
      else                 div_cnt <= div_cnt + DIV_W'(1);
   end

   // Memory is fully cleared by reset so a mid-stream reset leaves no stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
      end else if (pop && head_ok) begin
         mem[MEM_AW'(head_ent.addr)] <= head_ent.data;
      end
   end

   // Status, response and read-port registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt  <= '0;
         err     <= 1'b0;
         resp    <= '0;
         rd_data <= '0;
      end else begin
         if (pop && head_ok) wr_cnt <= wr_cnt + 16'd1;

         // A bad-address pop outranks a simultaneous clear.
         if (pop && !head_ok) err <= 1'b1;
         else if (err_clr)    err <= 1'b0;

         if (accept) resp <= bus.s_data_in + WIDTH'(1);

         rd_data <= (rd_addr <= MAX_ADDR) ? mem[MEM_AW'(rd_addr)] : '0;
      end
   end

endmodule

// File: tb/tb_slave_mem.sv
// Bench for slave_mem: two instances (drain divider 3 and 1) checked every cycle
// against a queue-based reference model, plus table vectors and directed corner sequences.
module tb_slave_mem;
   import slave_mem_pkg::*;

   localparam int MAXA = int'(MAX_ADDR);

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp_rd;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   int   cyc_n = 0;
   bit   chk_en;

   logic       v    [2];
   logic [7:0] a    [2];
   logic [7:0] wd   [2];
   logic [7:0] rda  [2];
   logic       eclr [2];
   logic       rdy  [2];
   logic [7:0] sdo  [2];
   logic [7:0] rdd  [2];
   logic [15:0] wcnt [2];
   logic       errq [2];
   logic [2:0] lvl  [2];

   slave_mem_if #(.WIDTH(8), .ADDR_W(8)) bus0 ();
   slave_mem_if #(.WIDTH(8), .ADDR_W(8)) bus1 ();

   assign bus0.valid     = v[0];
   assign bus0.addr      = a[0];
   assign bus0.s_data_in = wd[0];
   assign rdy[0]         = bus0.ready;
   assign sdo[0]         = bus0.s_data_out;
   assign bus1.valid     = v[1];
   assign bus1.addr      = a[1];
   assign bus1.s_data_in = wd[1];
   assign rdy[1]         = bus1.ready;
   assign sdo[1]         = bus1.s_data_out;

   slave_mem #(.DRAIN_DIV(3)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .rd_addr(rda[0]), .rd_data(rdd[0]),
      .wr_cnt(wcnt[0]), .err(errq[0]), .err_clr(eclr[0]), .fifo_level(lvl[0]));

   slave_mem #(.DRAIN_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .rd_addr(rda[1]), .rd_data(rdd[1]),
      .wr_cnt(wcnt[1]), .err(errq[1]), .err_clr(eclr[1]), .fifo_level(lvl[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Reference model: a 4-deep queue, a memory array and drain ticks every
   // div-th clock edge counted from reset release.
   logic [7:0]  m_mem  [2][49];
   logic [15:0] m_q    [2][4];
   int          m_cnt  [2];
   int          m_cyc  [2];
   logic [15:0] m_wr   [2];
   logic        m_err  [2];
   logic [7:0]  m_resp [2];
   logic [7:0]  m_rd   [2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0; m_cyc[d] = 0; m_wr[d] = 16'h0;
         m_err[d] = 1'b0; m_resp[d] = 8'h00; m_rd[d] = 8'h00;
         for (int k = 0; k < 49; k++) m_mem[d][k] = 8'h00;
      end
   endtask

   task automatic model_edge(input int d);
      int         dv;
      int         ea;
      int         ra;
      bit         do_pop;
      bit         do_push;
      bit         set_err;
      logic [15:0] e;
      dv      = (d == 0) ? 3 : 1;
      do_pop  = ((m_cyc[d] % dv) == dv - 1) && (m_cnt[d] > 0);
      do_push = v[d] && (m_cnt[d] < 4);
      set_err = 1'b0;
      ra      = int'(rda[d]);
      m_rd[d] = 8'h00;
      if (ra <= MAXA) m_rd[d] = m_mem[d][ra];
      if (do_pop) begin
         e = m_q[d][0];
         for (int k = 0; k < 3; k++) m_q[d][k] = m_q[d][k+1];
         m_cnt[d]--;
         ea = int'(e[15:8]);
         if (ea <= MAXA) begin
            m_mem[d][ea] = e[7:0];
            m_wr[d]      = m_wr[d] + 16'd1;
         end else begin
            set_err = 1'b1;
         end
      end
      if (set_err)      m_err[d] = 1'b1;
      else if (eclr[d]) m_err[d] = 1'b0;
      if (do_push) begin
         m_q[d][m_cnt[d]] = {a[d], wd[d]};
         m_cnt[d]++;
         m_resp[d] = wd[d] + 8'd1;
      end
      m_cyc[d]++;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else for (int d = 0; d < 2; d++) model_edge(d);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("ready%0d", d), 32'(rdy[d]), 32'(!rst && (m_cnt[d] < 4)));
            check($sformatf("s_data_out%0d", d), 32'(sdo[d]), 32'(m_resp[d]));
            check($sformatf("wr_cnt%0d", d), 32'(wcnt[d]), 32'(m_wr[d]));
            check($sformatf("err%0d", d), 32'(errq[d]), 32'(m_err[d]));
            check($sformatf("fifo_level%0d", d), 32'(lvl[d]), 32'(m_cnt[d]));
            check($sformatf("rd_data%0d", d), 32'(rdd[d]), 32'(m_rd[d]));
         end
      end
   end

   task automatic tick_c();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat and hold it until accepted; returns the accept-edge cycle number.
   task automatic send(input int d, input logic [7:0] ad, input logic [7:0] dt, output int acc_cyc);
      int n = 0;
      v[d] = 1'b1; a[d] = ad; wd[d] = dt;
      while (!rdy[d] && n < 50) begin
         tick_c();
         n++;
      end
      if (!rdy[d]) check("send_timeout", 32'(rdy[d]), 32'd1);
      else tick_c();
      acc_cyc = cyc_n;
      v[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      int n = 0;
      while (lvl[d] != 3'd0 && n < 100) begin
         tick_c();
         n++;
      end
      check("drain_timeout", 32'(lvl[d]), 32'd0);
      tick_c();
      tick_c();
   endtask

   vec_t tbl [7];
   int   acc [10];
   int   t;
   int   prev;
   int   n;

   initial begin
      n_cmp = 0; n_bad = 0; chk_en = 1'b0; rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         v[d] = 1'b0; a[d] = 8'h00; wd[d] = 8'h00; rda[d] = 8'h00; eclr[d] = 1'b0;
      end
      model_reset();
      tbl[0] = '{8'h05, 8'hA7, 8'hA7};
      tbl[1] = '{8'h00, 8'h11, 8'h11};
      tbl[2] = '{8'h30, 8'hFF, 8'hFF};
      tbl[3] = '{8'h31, 8'h55, 8'h00};
      tbl[4] = '{8'h2F, 8'h01, 8'h01};
      tbl[5] = '{8'h10, 8'h80, 8'h80};
      tbl[6] = '{8'hFF, 8'h12, 8'h00};
      chk_en = 1'b1;

      // Reset held three cycles, then idle read sweep.
      for (int i = 0; i < 3; i++) begin
         tick_c();
         check("ready_in_reset", 32'(rdy[0]), 32'd0);
      end
      rst = 1'b0;
      #1;
      check("ready_after_reset0", 32'(rdy[0]), 32'd1);
      check("ready_after_reset1", 32'(rdy[1]), 32'd1);
      for (int i = 0; i <= MAXA; i++) begin
         rda[0] = 8'(i); rda[1] = 8'(i);
         tick_c();
         check("rd_idle", 32'(rdd[0]), 32'd0);
      end
      check("wr_cnt_idle", 32'(wcnt[0]), 32'd0);

      // Single write at divider 3.
      send(0, 8'h05, 8'hA7, t);
      check("resp_A8", 32'(sdo[0]), 32'hA8);
      rda[0] = 8'h05;
      repeat (4) tick_c();
      check("rd_single", 32'(rdd[0]), 32'hA7);
      check("wr_cnt_single", 32'(wcnt[0]), 32'd1);

      // Full-rate drain: response wrap, then 49 back-to-back beats with no stall.
      send(1, 8'h00, 8'hFF, prev);
      check("resp_wrap", 32'(sdo[1]), 32'h00);
      for (int i = 0; i <= MAXA; i++) begin
         send(1, 8'(i), 8'(i) ^ 8'h5A, t);
         check("stream_gap", 32'(t - prev), 32'd1);
         check("stream_lvl_le1", 32'(lvl[1] <= 3'd1), 32'd1);
         prev = t;
      end
      drain(1);
      check("wr_cnt_stream", 32'(wcnt[1]), 32'd50);
      rda[1] = 8'h18; tick_c();
      check("rd_stream_18", 32'(rdd[1]), 32'(8'h18 ^ 8'h5A));
      rda[1] = 8'h30; tick_c();
      check("rd_stream_30", 32'(rdd[1]), 32'(8'h30 ^ 8'h5A));

      // Backpressure: valid held through ten beats at divider 3.
      for (int i = 0; i < 10; i++) send(0, 8'(i), 8'(i), acc[i]);
      for (int i = 1; i < 4; i++)  check("bp_gap_fill", 32'(acc[i] - acc[i-1]), 32'd1);
      for (int i = 6; i < 10; i++) check("bp_gap_steady", 32'(acc[i] - acc[i-1]), 32'd3);
      drain(0);
      for (int i = 0; i < 10; i++) begin
         rda[0] = 8'(i);
         tick_c();
         check("bp_rd", 32'(rdd[0]), 32'(i));
      end
      check("wr_cnt_bp", 32'(wcnt[0]), 32'd11);

      // Table vectors: write all, drain, read back expected contents.
      for (int i = 0; i < 7; i++) send(0, tbl[i].addr, tbl[i].data, t);
      drain(0);
      for (int i = 0; i < 7; i++) begin
         rda[0] = tbl[i].addr;
         tick_c();
         check($sformatf("tbl_rd_%0h", tbl[i].addr), 32'(rdd[0]), 32'(tbl[i].exp_rd));
      end
      check("wr_cnt_tbl", 32'(wcnt[0]), 32'd16);
      check("err_set", 32'(errq[0]), 32'd1);

      // err_clr alone clears; err_clr coinciding with a bad pop loses.
      eclr[0] = 1'b1; tick_c(); eclr[0] = 1'b0;
      check("err_clr", 32'(errq[0]), 32'd0);
      eclr[0] = 1'b1;
      send(0, 8'h31, 8'h55, t);
      n = 0;
      while (lvl[0] != 3'd0 && n < 10) begin
         tick_c();
         n++;
      end
      check("err_set_wins", 32'(errq[0]), 32'd1);
      eclr[0] = 1'b0;
      check("wr_cnt_bad", 32'(wcnt[0]), 32'd16);
      tick_c();
      check("err_sticky", 32'(errq[0]), 32'd1);
      eclr[0] = 1'b1; tick_c(); eclr[0] = 1'b0;
      check("err_clr2", 32'(errq[0]), 32'd0);

      // Random traffic on both instances; the per-cycle model comparison judges it.
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++) begin
            v[d]    = ($urandom_range(0, 9) < 6);
            a[d]    = 8'($urandom_range(0, 8'h33));
            wd[d]   = 8'($urandom);
            rda[d]  = 8'($urandom_range(0, 8'h34));
            eclr[d] = ($urandom_range(0, 15) == 0);
         end
         tick_c();
      end
      for (int d = 0; d < 2; d++) begin
         v[d] = 1'b0; eclr[d] = 1'b0;
      end
      drain(0);
      drain(1);

      // Reset with three beats queued.
      v[0] = 1'b1;
      n = 0;
      while (lvl[0] != 3'd3 && n < 40) begin
         a[0] = 8'h07; wd[0] = 8'(n);
         tick_c();
         n++;
      end
      check("lvl_before_rst", 32'(lvl[0]), 32'd3);
      rst = 1'b1;
      #1;
      check("rst_ready", 32'(rdy[0]), 32'd0);
      check("rst_level", 32'(lvl[0]), 32'd0);
      check("rst_wr_cnt", 32'(wcnt[0]), 32'd0);
      check("rst_resp", 32'(sdo[0]), 32'd0);
      v[0] = 1'b0;
      repeat (2) tick_c();
      rst = 1'b0;
      for (int i = 0; i <= MAXA; i++) begin
         rda[0] = 8'(i);
         tick_c();
         check("rd_after_rst", 32'(rdd[0]), 32'd0);
      end
      send(0, 8'h02, 8'h3C, t);
      rda[0] = 8'h02;
      repeat (4) tick_c();
      check("rd_fresh", 32'(rdd[0]), 32'h3C);
      check("wr_cnt_fresh", 32'(wcnt[0]), 32'd1);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
